// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase codes, phase ring, phase lengths and lamp decode for the crossing controller
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ALL_RED_B = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_A = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    typedef struct packed {
        logic ns_r;
        logic ns_y;
        logic ns_g;
        logic ew_r;
        logic ew_y;
        logic ew_g;
    } lamps_t;

    function automatic phase_e next_phase(phase_e p);
        case (p)
            ALL_RED_B: return NS_GREEN;
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED_A;
            ALL_RED_A: return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            default:   return ALL_RED_B;
        endcase
    endfunction

    function automatic int phase_len(phase_e p, int green_t, int yellow_t, int allred_t, int flash_t);
        case (p)
            NS_GREEN, EW_GREEN:   return green_t;
            NS_YELLOW, EW_YELLOW: return yellow_t;
            FLASH:                return flash_t;
            default:              return allred_t;
        endcase
    endfunction

    // In FLASH only the two yellows may be lit, both following flash_on.
    function automatic lamps_t lamp_decode(phase_e p, logic flash_on);
        lamps_t l;
        l.ns_g = p == NS_GREEN;
        l.ns_y = p == NS_YELLOW || (p == FLASH && flash_on);
        l.ns_r = !(p == NS_GREEN || p == NS_YELLOW || p == FLASH);
        l.ew_g = p == EW_GREEN;
        l.ew_y = p == EW_YELLOW || (p == FLASH && flash_on);
        l.ew_r = !(p == EW_GREEN || p == EW_YELLOW || p == FLASH);
        return l;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: loadable down-counter holding the cycles left in the current phase
module tl_phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;

    // Load wins over decrement; the controller always loads on the last cycle so 0 is never reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= CNT_W'(RST_VAL);
        else     count_q <= load_i ? load_val_i : count_q - CNT_W'(1);
    end

    assign count_o = count_q;
    assign last_o  = count_q == CNT_W'(1);

endmodule

// File: rtl/traffic_light_xing.sv
// traffic_light_xing: two-approach intersection controller with all-red clearance, request shortening and flash mode
module traffic_light_xing
    import traffic_light_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 60,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 3,
    parameter int SHORT_T  = 10,
    parameter int FLASH_T  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_ns,
    input  logic             req_ew,
    input  logic             flash_en,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green
);

    if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || SHORT_T < 1 || FLASH_T < 1 ||
        GREEN_T >= (1 << CNT_W) || YELLOW_T >= (1 << CNT_W) || ALLRED_T >= (1 << CNT_W) ||
        SHORT_T >= (1 << CNT_W) || FLASH_T >= (1 << CNT_W) || SHORT_T >= GREEN_T) begin : g_bad_params
        $error("traffic_light_xing: illegal phase length parameters");
    end

    phase_e           phase_q, phase_d;
    lamps_t           lamps_q;
    logic             flash_on_q, flash_on_d;
    logic             pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic             load, last, shorten;
    logic [CNT_W-1:0] load_val;

    tl_phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_T)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(load_val),
        .count_o   (count),
        .last_o    (last)
    );

    // A pending (or same-cycle) request for the other approach cuts a long green down to SHORT_T once.
    assign shorten = ((phase_q == NS_GREEN && (pend_ew_q || req_ew)) ||
                      (phase_q == EW_GREEN && (pend_ns_q || req_ns))) && int'(count) > SHORT_T + 1;

    // Next phase and timer load: flash entry/exit first, then phase expiry, then shortening.
    always_comb begin
        phase_d    = phase_q;
        flash_on_d = flash_on_q;
        load       = 1'b0;
        load_val   = '0;
        if (flash_en && phase_q != FLASH) begin
            phase_d    = FLASH;
            flash_on_d = 1'b1;
            load       = 1'b1;
            load_val   = CNT_W'(FLASH_T);
        end else if (phase_q == FLASH && !flash_en) begin
            phase_d  = ALL_RED_B;
            load     = 1'b1;
            load_val = CNT_W'(ALLRED_T);
        end else if (phase_q == FLASH) begin
            flash_on_d = flash_on_q ^ last;
            load       = last;
            load_val   = CNT_W'(FLASH_T);
        end else if (last) begin
            phase_d  = next_phase(phase_q);
            load     = 1'b1;
            load_val = CNT_W'(phase_len(phase_d, GREEN_T, YELLOW_T, ALLRED_T, FLASH_T));
        end else if (shorten) begin
            load     = 1'b1;
            load_val = CNT_W'(SHORT_T);
        end
    end

    // Requests latch unless their own approach is green or the crossing is flashing; entering green clears them.
    always_comb begin
        pend_ns_d = (phase_d == NS_GREEN && phase_q != NS_GREEN) ? 1'b0 :
                    pend_ns_q | (req_ns && phase_q != NS_GREEN && phase_q != FLASH);
        pend_ew_d = (phase_d == EW_GREEN && phase_q != EW_GREEN) ? 1'b0 :
                    pend_ew_q | (req_ew && phase_q != EW_GREEN && phase_q != FLASH);
    end

    // Phase, request latches and lamps registered together so lamps never lag the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= ALL_RED_B;
            lamps_q    <= lamp_decode(ALL_RED_B, 1'b0);
            flash_on_q <= 1'b0;
            pend_ns_q  <= 1'b0;
            pend_ew_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            lamps_q    <= lamp_decode(phase_d, flash_on_d);
            flash_on_q <= flash_on_d;
            pend_ns_q  <= pend_ns_d;
            pend_ew_q  <= pend_ew_d;
        end
    end

    assign phase     = phase_q;
    assign ns_red    = lamps_q.ns_r;
    assign ns_yellow = lamps_q.ns_y;
    assign ns_green  = lamps_q.ns_g;
    assign ew_red    = lamps_q.ew_r;
    assign ew_yellow = lamps_q.ew_y;
    assign ew_green  = lamps_q.ew_g;

endmodule

// File: tb/tb_traffic_light_xing.sv
// tb_traffic_light_xing: cycle model comparison plus pinned literal expectations for the crossing controller
module tb_traffic_light_xing;

    localparam int GT = 60, YT = 5, AT = 3, ST = 10, FT = 4;

    typedef struct {
        int ph;
        int cnt;
        bit pns;
        bit pew;
        bit fy;
    } model_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_ns = 1'b0, req_ew = 1'b0, flash_en = 1'b0;
    logic [7:0] count;
    logic [2:0] phase;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;

    int     checks = 0, failures = 0, e = 0;
    model_t m;

    traffic_light_xing dut (
        .clk(clk), .rst(rst), .req_ns(req_ns), .req_ew(req_ew), .flash_en(flash_en),
        .count(count), .phase(phase),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp);
        end
    endtask

    // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g}: green/yellow approach lit as such, other red; flashing lights yellows only.
    function automatic logic [5:0] exp_lamps(int ph, bit fy);
        logic [2:0] ns, ew;
        ns = ph == 1 ? 3'b001 : ph == 2 ? 3'b010 : ph == 6 ? {1'b0, fy, 1'b0} : 3'b100;
        ew = ph == 4 ? 3'b001 : ph == 5 ? 3'b010 : ph == 6 ? {1'b0, fy, 1'b0} : 3'b100;
        return {ns, ew};
    endfunction

    function automatic model_t step(model_t c, bit rn, bit re, bit fe);
        int     ring[6] = '{1, 2, 3, 4, 5, 0};
        int     len[6]  = '{AT, GT, YT, AT, GT, YT};
        model_t n = c;
        if (c.ph != 6) begin
            if (rn && c.ph != 1) n.pns = 1;
            if (re && c.ph != 4) n.pew = 1;
        end
        if (c.ph == 6) begin
            if (!fe) begin n.ph = 0; n.cnt = AT; end
            else if (c.cnt == 1) begin n.cnt = FT; n.fy = !c.fy; end
            else n.cnt = c.cnt - 1;
        end else if (fe) begin
            n.ph = 6; n.cnt = FT; n.fy = 1;
        end else if (c.cnt == 1) begin
            n.ph  = ring[c.ph];
            n.cnt = len[n.ph];
            if (n.ph == 1) n.pns = 0;
            if (n.ph == 4) n.pew = 0;
        end else if (c.cnt > ST + 1 && ((c.ph == 1 && (c.pew || re)) || (c.ph == 4 && (c.pns || rn)))) begin
            n.cnt = ST;
        end else begin
            n.cnt = c.cnt - 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{ph: 0, cnt: AT, pns: 0, pew: 0, fy: 0};
        else     m <= step(m, req_ns, req_ew, flash_en);
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_count", int'(count), m.cnt);
            chk("model_phase", int'(phase), m.ph);
            chk("model_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), int'(exp_lamps(m.ph, m.fy)));
            chk("model_pend_ns", int'(dut.pend_ns_q), int'(m.pns));
            chk("model_pend_ew", int'(dut.pend_ew_q), int'(m.pew));
        end
    end

    task automatic adv_to(input int t);
        while (e < t) begin
            @(negedge clk);
            e++;
        end
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_count", int'(count), 3);
        chk("reset_phase", int'(phase), 0);
        chk("reset_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 6'b100100);
        rst = 1'b0;
        adv_to(1);   chk("e1_count", int'(count), 2);
        adv_to(2);   chk("e2_count", int'(count), 1);
        adv_to(3);   chk("e3_phase", int'(phase), 1);
                     chk("e3_count", int'(count), 60);
                     chk("e3_ns_green", int'(ns_green), 1);
                     chk("e3_ew_red", int'(ew_red), 1);
        adv_to(63);  chk("e63_phase", int'(phase), 2);
                     chk("e63_count", int'(count), 5);
        adv_to(68);  chk("e68_phase", int'(phase), 3);
        adv_to(71);  chk("e71_phase", int'(phase), 4);
                     chk("e71_count", int'(count), 60);
        adv_to(139); chk("e139_phase", int'(phase), 1);
        // request shortens NS green at count 40
        adv_to(159); chk("e159_count", int'(count), 40);
        req_ew = 1'b1;
        adv_to(160); req_ew = 1'b0;
                     chk("short_count", int'(count), 10);
                     chk("short_pend_ew", int'(dut.pend_ew_q), 1);
        adv_to(170); chk("short_yellow", int'(phase), 2);
        // request on the edge entering EW green is lost
        adv_to(177); req_ew = 1'b1;
        adv_to(178); req_ew = 1'b0;
                     chk("ew_entry_phase", int'(phase), 4);
                     chk("ew_entry_pend_ew", int'(dut.pend_ew_q), 0);
        // late request: no shortening
        adv_to(298); chk("late_pre_count", int'(count), 8);
        req_ew = 1'b1;
        adv_to(299); req_ew = 1'b0;
                     chk("late_count", int'(count), 7);
        adv_to(314); chk("late_ew_phase", int'(phase), 4);
                     chk("late_pend_ew", int'(dut.pend_ew_q), 0);
        // same-approach request ignored
        adv_to(392); chk("same_pre_count", int'(count), 50);
        req_ns = 1'b1;
        adv_to(393); req_ns = 1'b0;
                     chk("same_count", int'(count), 49);
                     chk("same_pend_ns", int'(dut.pend_ns_q), 0);
        adv_to(460); chk("same_ew_unshort", int'(count), 50);
        // flash mode from mid EW green
        flash_en = 1'b1;
        adv_to(461); chk("flash_phase", int'(phase), 6);
                     chk("flash_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 6'b010010);
        adv_to(465); chk("flash_off", int'(ns_yellow | ew_yellow), 0);
                     chk("flash_off_count", int'(count), 4);
        adv_to(469); chk("flash_on_again", int'(ns_yellow & ew_yellow), 1);
        adv_to(470); flash_en = 1'b0;
        adv_to(471); chk("unflash_phase", int'(phase), 0);
                     chk("unflash_count", int'(count), 3);
        adv_to(474); chk("unflash_green", int'(phase), 1);
        // asynchronous reset mid NS yellow
        adv_to(535); chk("pre_rst_phase", int'(phase), 2);
                     chk("pre_rst_count", int'(count), 4);
        #2 rst = 1'b1;
        #1 chk("arst_count", int'(count), 3);
           chk("arst_phase", int'(phase), 0);
           chk("arst_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 6'b100100);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        adv_to(3);   chk("post_rst_phase", int'(phase), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_xing.md
Name: traffic_light_xing

Overview:
- Parametrised two-approach intersection controller: north-south (NS) and east-west (EW).
- Successor to the single-approach traffic light. Adds:
  - a per-approach red/yellow/green triple;
  - all-red clearance phases;
  - latched service requests that shorten the opposing green;
  - a flashing-yellow maintenance mode.
- Sits between the intersection sequencer and the lamp drivers/countdown display.

Parameters:
- CNT_W, 8, countdown width in bits.
- GREEN_T, 60, green phase length in cycles.
- YELLOW_T, 5, yellow phase length in cycles.
- ALLRED_T, 3, all-red clearance length in cycles.
- SHORT_T, 10, shortened remaining green after a request.
- FLASH_T, 4, half-period of flashing yellow in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_ns  in  1  service request for NS approach; single-cycle pulse or level.
- req_ew  in  1  service request for EW approach.
- flash_en  in  1  level; maintenance flashing-yellow mode.
- count  out  CNT_W  cycles remaining in current phase.
- phase  out  3  current phase code, from the package.
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps.
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps.

Behaviour:
- Reset (async assert, sync release):
  - phase=ALL_RED_B, count=ALLRED_T.
  - ns_red=ew_red=1, all other lamps 0, pending bits 0.
- Phase ring: ALL_RED_B -> NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B.
- Phase lengths: GREEN_T / YELLOW_T / ALLRED_T respectively.
- Timing rule, per edge:
  - If count>1: count decrements.
  - If count==1: phase advances and count loads the next phase's length.
  - Each phase therefore lasts exactly its length in cycles. count is never 0 outside reset.
- Lamps are a pure decode of phase and are registered with it.
  - Exactly one lamp per approach is lit.
  - The approach not in green/yellow shows red.
  - Both red in ALL_RED_A/B.
- Requests:
  - req_ns sets pend_ns; req_ew sets pend_ew. Setting is sticky.
  - pend_ns is cleared on the edge entering NS_GREEN; pend_ew is cleared entering EW_GREEN.
  - A request arriving on that same edge is lost (the clear wins). The bench checks this.
- Shortening:
  - Condition: phase==NS_GREEN, pend_ew=1 (or req_ew=1 this cycle), count>SHORT_T+1.
  - Effect: next count=SHORT_T instead of count-1. EW_GREEN with NS requests is symmetric.
  - If count<=SHORT_T+1: normal decrement.
  - Shortening occurs at most once per green; count then decreases monotonically.
  - A request for the approach currently green is ignored and does not set pending.
- Flash:
  - flash_en=1 from any phase: the next edge enters FLASH with count=FLASH_T.
  - In FLASH: all red/green lamps 0; ns_yellow=ew_yellow toggle every FLASH_T cycles, starting lit; count reloads FLASH_T on each toggle.
  - Pending bits are held.
  - flash_en=0 while in FLASH: the next edge enters ALL_RED_B with count=ALLRED_T.
- Reset mid-phase: immediately returns to the reset state.
- Elaboration checks (assert): all lengths >=1, all lengths <2**CNT_W, SHORT_T<GREEN_T.

Decomposition:
- Package traffic_light_pkg:
  - phase enum (3-bit): ALL_RED_B=0, NS_GREEN=1, NS_YELLOW=2, ALL_RED_A=3, EW_GREEN=4, EW_YELLOW=5, FLASH=6;
  - a function mapping phase to its default length;
  - the lamp-decode function.
- One sub-module, tl_phase_timer:
  - loadable CNT_W down-counter;
  - inputs load/load_val;
  - output last (count==1).
- The FSM, request latches and lamp decode stay in the top.

Test Plan (defaults; edge numbering starts at 1 after reset release):
- Reset then idle:
  - edges 1-2: count 2,1 in ALL_RED_B;
  - edge 3: NS_GREEN, count=60, ns_green=1/ew_red=1;
  - edge 63: NS_YELLOW count=5;
  - edge 68: ALL_RED_A;
  - edge 71: EW_GREEN count=60;
  - edge 139: NS_GREEN again.
- Request shortens: req_ew pulse while NS_GREEN count=40 -> next count=10, then 9..1 -> NS_YELLOW; pend_ew clears on EW_GREEN entry.
- Late request: req_ew while NS_GREEN count=8 -> count=7 (no shortening); EW_GREEN still reached, then pend_ew=0.
- Same-approach request: req_ns during NS_GREEN count=50 -> count=49, pend_ns stays 0; the following EW_GREEN is not shortened.
- Flash: flash_en=1 mid EW_GREEN:
  - next edge: FLASH, both yellow=1, no red/green;
  - yellows toggle every 4 edges;
  - drop flash_en -> ALL_RED_B count=3, then NS_GREEN.
- Async reset asserted mid NS_YELLOW -> outputs go to reset values without a clock edge; count=3.
